// File: rtl/ahbl_arbiter_2m.sv
// ahbl_arbiter_2m
// Two-master AHB-lite arbiter. Each master's address phase is captured in a
// hold register, arbitrated (round-robin or fixed priority) and re-issued on
// the shared bus as a single NONSEQ transfer one cycle later. A master that
// is waiting for the bus sees HREADY_Mx low until its transfer has finished.
module ahbl_arbiter_2m #(
    parameter bit ARB_RR     = 1'b1,
    parameter bit DEF_MASTER = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    // master 0 (CPU)
    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic [2:0]  HSIZE_M0,
    input  logic [31:0] HWDATA_M0,
    output logic [31:0] HRDATA_M0,
    output logic        HREADY_M0,
    // master 1 (DMA)
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [31:0] HWDATA_M1,
    output logic [31:0] HRDATA_M1,
    output logic        HREADY_M1,
    // shared bus
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    output logic        HMASTER
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_DATA = 2'b10
    } mst_state_e;

    localparam logic [1:0] TRANS_IDLE    = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ  = 2'b10;

    // Pick the master to present on the bus when not locked.
    // With both pending, round-robin favours the one that did not win last.
    function automatic logic arb_pick(input logic [1:0] pend,
                                      input logic       last,
                                      input logic       rr);
        logic pick;
        case (pend)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = rr ? ~last : 1'b0;
            default: pick = 1'b0;
        endcase
        return pick;
    endfunction

    // Per-master views of the input ports, indexed by master number.
    logic [31:0] m_haddr_s  [2];
    logic        m_hwrite_s [2];
    logic [2:0]  m_hsize_s  [2];
    logic [1:0]  req_s;

    assign m_haddr_s[0]  = HADDR_M0;
    assign m_haddr_s[1]  = HADDR_M1;
    assign m_hwrite_s[0] = HWRITE_M0;
    assign m_hwrite_s[1] = HWRITE_M1;
    assign m_hsize_s[0]  = HSIZE_M0;
    assign m_hsize_s[1]  = HSIZE_M1;
    // Only HTRANS[1] matters: SEQ is treated like NONSEQ, BUSY like IDLE.
    assign req_s         = {HTRANS_M1[1], HTRANS_M0[1]};

    logic unused_htrans_s;
    assign unused_htrans_s = HTRANS_M0[0] ^ HTRANS_M1[0];

    // State and hold registers.
    mst_state_e  state_r      [2];
    mst_state_e  state_nxt_s  [2];
    logic [31:0] hold_addr_r  [2];
    logic        hold_write_r [2];
    logic [2:0]  hold_size_r  [2];
    logic [1:0]  cap_s;
    logic [1:0]  hready_m_s;

    // Arbitration state.
    logic        last_r;
    logic        down_r;
    logic        lock_r;
    logic        lock_sel_r;
    logic [1:0]  pend_s;
    logic        asel_s;
    logic        bus_req_s;
    logic        accept_s;
    logic [1:0]  gnt_s;

    // Masters currently waiting for the bus.
    always_comb begin
        pend_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (state_r[i] == ST_PEND) begin
                pend_s[i] = 1'b1;
            end else begin
                pend_s[i] = 1'b0;
            end
        end
    end

    // Address-phase selection; frozen while a NONSEQ is being stretched.
    always_comb begin
        asel_s = 1'b0;
        if (lock_r) begin
            asel_s = lock_sel_r;
        end else begin
            asel_s = arb_pick(pend_s, last_r, ARB_RR);
        end
    end

    assign bus_req_s = pend_s[asel_s];
    assign accept_s  = bus_req_s & HREADY;
    assign gnt_s     = accept_s ? (asel_s ? 2'b10 : 2'b01) : 2'b00;

    // Per-master next state, capture strobe and HREADY_Mx.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_nxt_s[i] = state_r[i];
            cap_s[i]       = 1'b0;
            hready_m_s[i]  = 1'b1;
            case (state_r[i])
                ST_IDLE: begin
                    hready_m_s[i] = 1'b1;
                    if (req_s[i]) begin
                        cap_s[i]       = 1'b1;
                        state_nxt_s[i] = ST_PEND;
                    end else begin
                        state_nxt_s[i] = ST_IDLE;
                    end
                end
                ST_PEND: begin
                    hready_m_s[i] = 1'b0;
                    if (gnt_s[i]) begin
                        state_nxt_s[i] = ST_DATA;
                    end else begin
                        state_nxt_s[i] = ST_PEND;
                    end
                end
                ST_DATA: begin
                    // The bus data phase belongs to this master here.
                    hready_m_s[i] = HREADY;
                    if (HREADY) begin
                        if (req_s[i]) begin
                            cap_s[i]       = 1'b1;
                            state_nxt_s[i] = ST_PEND;
                        end else begin
                            state_nxt_s[i] = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s[i] = ST_DATA;
                    end
                end
                default: begin
                    hready_m_s[i]  = 1'b1;
                    state_nxt_s[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Per-master state registers and captured address/control.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 2; i++) begin
                state_r[i]      <= ST_IDLE;
                hold_addr_r[i]  <= 32'h0000_0000;
                hold_write_r[i] <= 1'b0;
                hold_size_r[i]  <= 3'b000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_r[i] <= state_nxt_s[i];
                if (cap_s[i]) begin
                    hold_addr_r[i]  <= m_haddr_s[i];
                    hold_write_r[i] <= m_hwrite_s[i];
                    hold_size_r[i]  <= m_hsize_s[i];
                end
            end
        end
    end

    // Round-robin history, data-phase owner and address-phase lock.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_r     <= 1'b1;
            down_r     <= DEF_MASTER;
            lock_r     <= 1'b0;
            lock_sel_r <= 1'b0;
        end else begin
            if (accept_s) begin
                last_r <= asel_s;
                down_r <= asel_s;
            end
            lock_r     <= bus_req_s & ~HREADY;
            lock_sel_r <= asel_s;
        end
    end

    // Shared bus address/control come straight from the selected hold register.
    assign HTRANS    = bus_req_s ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = hold_addr_r[asel_s];
    assign HWRITE    = hold_write_r[asel_s];
    assign HSIZE     = hold_size_r[asel_s];

    // Data phase follows the data-phase owner.
    assign HWDATA    = down_r ? HWDATA_M1 : HWDATA_M0;
    assign HMASTER   = down_r;

    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;
    assign HREADY_M0 = hready_m_s[0];
    assign HREADY_M1 = hready_m_s[1];

endmodule

// File: tb/tb_ahbl_arbiter_2m.sv
// Testbench for ahbl_arbiter_2m: directed scenarios plus randomized traffic
// checked against a transaction-level model of masters, arbiter and slave.
module tb_ahbl_arbiter_2m;

    localparam bit ARB_RR     = 1'b1;
    localparam bit DEF_MASTER = 1'b0;

    logic        HCLK, HRESETn;
    logic [31:0] HADDR_M0, HWDATA_M0, HRDATA_M0, HADDR_M1, HWDATA_M1, HRDATA_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1, HTRANS;
    logic        HWRITE_M0, HWRITE_M1, HREADY_M0, HREADY_M1, HWRITE, HREADY, HMASTER;
    logic [2:0]  HSIZE_M0, HSIZE_M1, HSIZE;
    logic [31:0] HADDR, HWDATA, HRDATA;

    int checks = 0;
    int errors = 0;
    int grants[$];

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        m;
    } txn_t;

    ahbl_arbiter_2m #(.ARB_RR(ARB_RR), .DEF_MASTER(DEF_MASTER)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
        .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0), .HRDATA_M0(HRDATA_M0), .HREADY_M0(HREADY_M0),
        .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1), .HRDATA_M1(HRDATA_M1), .HREADY_M1(HREADY_M1),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HMASTER(HMASTER)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic idle_masters();
        HTRANS_M0 = 2'b00; HADDR_M0 = 32'h0; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'd2; HWDATA_M0 = 32'h0;
        HTRANS_M1 = 2'b00; HADDR_M1 = 32'h0; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'd2; HWDATA_M1 = 32'h0;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        idle_masters();
        HREADY = 1'b1;
        HRDATA = 32'h0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        idle_masters();
        HREADY = 1'b0;
        HRDATA = 32'h0;
        @(negedge HCLK); #1;
        checks++; if ({HREADY_M0, HREADY_M1} !== 2'b11) begin errors++; $display("FAIL rst_hready_m got=%b exp=11", {HREADY_M0, HREADY_M1}); end
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans got=%b exp=00", HTRANS); end
        checks++; if (HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr got=%h exp=0", HADDR); end
        checks++; if ({HWRITE, HSIZE} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl got=%b exp=0000", {HWRITE, HSIZE}); end
        checks++; if (HMASTER !== DEF_MASTER) begin errors++; $display("FAIL rst_hmaster got=%b exp=%b", HMASTER, DEF_MASTER); end
        HREADY = 1'b1;
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK); #1;
        checks++; if (HTRANS !== 2'b00) begin errors++; $display("FAIL rst_post_htrans got=%b exp=00", HTRANS); end
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge HCLK);
        HTRANS_M0 = 2'b10; HADDR_M0 = 32'h2000_0010; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'd2;
        #1;
        checks++; if (HREADY_M0 !== 1'b1 || HTRANS !== 2'b00) begin errors++; $display("FAIL rd_c0 got rdy=%b tr=%b exp rdy=1 tr=00", HREADY_M0, HTRANS); end
        @(negedge HCLK);
        HTRANS_M0 = 2'b00;
        #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h2000_0010) begin errors++; $display("FAIL rd_issue got tr=%b a=%h exp tr=10 a=20000010", HTRANS, HADDR); end
        checks++; if (HWRITE !== 1'b0 || HSIZE !== 3'd2) begin errors++; $display("FAIL rd_ctrl got w=%b s=%0d exp w=0 s=2", HWRITE, HSIZE); end
        checks++; if (HREADY_M0 !== 1'b0) begin errors++; $display("FAIL rd_stall got=%b exp=0", HREADY_M0); end
        @(negedge HCLK);
        HRDATA = 32'h1234_5678;
        #1;
        checks++; if (HTRANS !== 2'b00 || HREADY_M0 !== 1'b1) begin errors++; $display("FAIL rd_data got tr=%b rdy=%b exp tr=00 rdy=1", HTRANS, HREADY_M0); end
        checks++; if (HRDATA_M0 !== 32'h1234_5678 || HMASTER !== 1'b0) begin errors++; $display("FAIL rd_rdata got d=%h hm=%b exp d=12345678 hm=0", HRDATA_M0, HMASTER); end
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge HCLK);
        HTRANS_M0 = 2'b10; HADDR_M0 = 32'h4800_0000; HWRITE_M0 = 1'b1;
        HTRANS_M1 = 2'b10; HADDR_M1 = 32'h0000_0100; HWRITE_M1 = 1'b0;
        @(negedge HCLK);
        HTRANS_M0 = 2'b00; HTRANS_M1 = 2'b00; HWDATA_M0 = 32'hA5A5_0001; HWDATA_M1 = 32'h7777_7777;
        #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h4800_0000 || HWRITE !== 1'b1) begin errors++; $display("FAIL cont_first got tr=%b a=%h w=%b exp tr=10 a=48000000 w=1", HTRANS, HADDR, HWRITE); end
        checks++; if ({HREADY_M0, HREADY_M1} !== 2'b00) begin errors++; $display("FAIL cont_stall got=%b exp=00", {HREADY_M0, HREADY_M1}); end
        @(negedge HCLK); #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0100 || HWRITE !== 1'b0) begin errors++; $display("FAIL cont_second got tr=%b a=%h w=%b exp tr=10 a=00000100 w=0", HTRANS, HADDR, HWRITE); end
        checks++; if (HMASTER !== 1'b0 || HWDATA !== 32'hA5A5_0001) begin errors++; $display("FAIL cont_m0data got hm=%b d=%h exp hm=0 d=a5a50001", HMASTER, HWDATA); end
        checks++; if ({HREADY_M0, HREADY_M1} !== 2'b10) begin errors++; $display("FAIL cont_rdy got=%b exp=10", {HREADY_M0, HREADY_M1}); end
        @(negedge HCLK);
        HRDATA = 32'h0BAD_BEEF;
        #1;
        checks++; if (HTRANS !== 2'b00 || HMASTER !== 1'b1) begin errors++; $display("FAIL cont_m1data got tr=%b hm=%b exp tr=00 hm=1", HTRANS, HMASTER); end
        checks++; if (HREADY_M1 !== 1'b1 || HRDATA_M1 !== 32'h0BAD_BEEF) begin errors++; $display("FAIL cont_rdata got rdy=%b d=%h exp rdy=1 d=0badbeef", HREADY_M1, HRDATA_M1); end
    endtask

    task automatic test_wait_lock();
        @(negedge HCLK);
        HTRANS_M0 = 2'b10; HADDR_M0 = 32'h3000_0000; HWRITE_M0 = 1'b0;
        HTRANS_M1 = 2'b10; HADDR_M1 = 32'h0000_0100; HWRITE_M1 = 1'b0;
        @(negedge HCLK);
        HTRANS_M0 = 2'b00; HTRANS_M1 = 2'b00;
        #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h3000_0000) begin errors++; $display("FAIL wait_first got tr=%b a=%h exp tr=10 a=30000000", HTRANS, HADDR); end
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            HREADY = 1'b0;
            #1;
            checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h0000_0100) begin errors++; $display("FAIL wait_frozen%0d got tr=%b a=%h exp tr=10 a=00000100", k, HTRANS, HADDR); end
            checks++; if ({HREADY_M0, HREADY_M1, HMASTER} !== 3'b000) begin errors++; $display("FAIL wait_stall%0d got=%b exp=000", k, {HREADY_M0, HREADY_M1, HMASTER}); end
        end
        @(negedge HCLK);
        HREADY = 1'b1;
        #1;
        checks++; if (HREADY_M0 !== 1'b1 || HTRANS !== 2'b10 || HADDR !== 32'h0000_0100) begin errors++; $display("FAIL wait_release got rdy=%b tr=%b a=%h exp rdy=1 tr=10 a=00000100", HREADY_M0, HTRANS, HADDR); end
        @(negedge HCLK); #1;
        checks++; if (HTRANS !== 2'b00 || HMASTER !== 1'b1 || HREADY_M1 !== 1'b1) begin errors++; $display("FAIL wait_m1data got tr=%b hm=%b rdy=%b exp tr=00 hm=1 rdy=1", HTRANS, HMASTER, HREADY_M1); end
    endtask

    task automatic test_m1_write();
        @(negedge HCLK);
        HTRANS_M1 = 2'b10; HADDR_M1 = 32'h4900_0004; HWRITE_M1 = 1'b1; HWDATA_M0 = 32'h1111_1111;
        @(negedge HCLK);
        HTRANS_M1 = 2'b00; HWDATA_M1 = 32'hCAFE_F00D;
        #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h4900_0004 || HWRITE !== 1'b1) begin errors++; $display("FAIL wr_issue got tr=%b a=%h w=%b exp tr=10 a=49000004 w=1", HTRANS, HADDR, HWRITE); end
        @(negedge HCLK); #1;
        checks++; if (HWDATA !== 32'hCAFE_F00D || HMASTER !== 1'b1) begin errors++; $display("FAIL wr_data got d=%h hm=%b exp d=cafef00d hm=1", HWDATA, HMASTER); end
        checks++; if (HREADY_M1 !== 1'b1) begin errors++; $display("FAIL wr_rdy got=%b exp=1", HREADY_M1); end
    endtask

    task automatic test_reset_mid();
        @(negedge HCLK);
        HTRANS_M1 = 2'b10; HADDR_M1 = 32'h0000_0100; HWRITE_M1 = 1'b0;
        @(negedge HCLK);
        HTRANS_M1 = 2'b00;
        HTRANS_M0 = 2'b10; HADDR_M0 = 32'h5000_0000; HWRITE_M0 = 1'b0;
        @(negedge HCLK);
        HTRANS_M0 = 2'b00; HREADY = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h5000_0000 || {HREADY_M0, HREADY_M1} !== 2'b00) begin errors++; $display("FAIL mid_pre got tr=%b a=%h rdy=%b exp tr=10 a=50000000 rdy=00", HTRANS, HADDR, {HREADY_M0, HREADY_M1}); end
        #2 HRESETn = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b00 || HADDR !== 32'h0) begin errors++; $display("FAIL mid_bus got tr=%b a=%h exp tr=00 a=0", HTRANS, HADDR); end
        checks++; if ({HREADY_M0, HREADY_M1} !== 2'b11 || HMASTER !== DEF_MASTER) begin errors++; $display("FAIL mid_rdy got rdy=%b hm=%b exp rdy=11 hm=%b", {HREADY_M0, HREADY_M1}, HMASTER, DEF_MASTER); end
        @(negedge HCLK);
        HRESETn = 1'b1; HREADY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK); #1;
            checks++; if (HTRANS !== 2'b00 || {HREADY_M0, HREADY_M1} !== 2'b11) begin errors++; $display("FAIL mid_post%0d got tr=%b rdy=%b exp tr=00 rdy=11", k, HTRANS, {HREADY_M0, HREADY_M1}); end
        end
    endtask

    // Randomized traffic against a transaction-level model. Masters hold an
    // address until HREADY_Mx accepts it; the slave inserts random waits.
    task automatic run_traffic(input int n, input int issue_pct, input int max_wait);
        txn_t mlist[2][$];
        txn_t pq[2][$];
        txn_t addr_t[2];
        txn_t dp_t[2];
        txn_t s_t;
        txn_t t;
        bit   addr_v[2];
        bit   dp_v[2];
        bit   s_v, last, prev_lock, prev_sel, sel_obs, exp_sel, exp_r, busy;
        logic [38:0] prev_ctl;
        logic [1:0]  exp_tr;
        logic [31:0] rd_m;
        int   s_wait, accepts, cyc;

        do_reset();
        grants.delete();
        last = 1'b1; s_v = 1'b0; prev_lock = 1'b0; prev_sel = 1'b0; s_wait = 0; accepts = 0; cyc = 0;
        s_t = '0; prev_ctl = '0;
        for (int m = 0; m < 2; m++) begin
            addr_v[m] = 1'b0; dp_v[m] = 1'b0; addr_t[m] = '0; dp_t[m] = '0;
            for (int i = 0; i < n; i++) begin
                t.addr = $urandom; t.addr[31] = m[0]; t.addr[1:0] = 2'b00;
                t.wr = 1'($urandom_range(0, 1)); t.size = 3'd2; t.wdata = $urandom; t.m = m[0];
                mlist[m].push_back(t);
            end
        end
        busy = 1'b1;
        while (busy && cyc < 4000) begin
            @(negedge HCLK);
            cyc++;
            HREADY = s_v ? (s_wait == 0) : 1'b1;
            HRDATA = (s_v && !s_t.wr) ? rd_fn(s_t.addr) : $urandom;
            for (int m = 0; m < 2; m++) begin
                if (!addr_v[m] && mlist[m].size() != 0 && $urandom_range(1, 100) <= issue_pct) begin
                    addr_t[m] = mlist[m].pop_front();
                    addr_v[m] = 1'b1;
                end
            end
            HTRANS_M0 = addr_v[0] ? 2'b10 : 2'b00; HADDR_M0 = addr_v[0] ? addr_t[0].addr : $urandom;
            HWRITE_M0 = addr_t[0].wr; HSIZE_M0 = addr_t[0].size;
            HWDATA_M0 = (dp_v[0] && dp_t[0].wr) ? dp_t[0].wdata : $urandom;
            HTRANS_M1 = addr_v[1] ? 2'b10 : 2'b00; HADDR_M1 = addr_v[1] ? addr_t[1].addr : $urandom;
            HWRITE_M1 = addr_t[1].wr; HSIZE_M1 = addr_t[1].size;
            HWDATA_M1 = (dp_v[1] && dp_t[1].wr) ? dp_t[1].wdata : $urandom;
            #1;
            // Bus carries a NONSEQ exactly while some captured transfer is not yet issued.
            exp_tr = (pq[0].size() != 0 || pq[1].size() != 0) ? 2'b10 : 2'b00;
            checks++; if (HTRANS !== exp_tr) begin errors++; $display("FAIL rnd_htrans cyc=%0d got=%b exp=%b", cyc, HTRANS, exp_tr); end
            for (int m = 0; m < 2; m++) begin
                exp_r = (pq[m].size() != 0) ? 1'b0 : (dp_v[m] ? HREADY : 1'b1);
                checks++; if ((m == 0 ? HREADY_M0 : HREADY_M1) !== exp_r) begin errors++; $display("FAIL rnd_hready_m%0d cyc=%0d got=%b exp=%b", m, cyc, (m == 0 ? HREADY_M0 : HREADY_M1), exp_r); end
            end
            if (prev_lock) begin
                checks++; if ({HADDR, HWRITE, HSIZE} !== prev_ctl) begin errors++; $display("FAIL rnd_lock cyc=%0d got=%h exp=%h", cyc, {HADDR, HWRITE, HSIZE}, prev_ctl); end
            end
            // Slave side of the data phase.
            if (s_v) begin
                checks++; if (HMASTER !== s_t.m) begin errors++; $display("FAIL rnd_hmaster cyc=%0d got=%b exp=%b", cyc, HMASTER, s_t.m); end
                if (HREADY) begin
                    if (s_t.wr) begin
                        checks++; if (HWDATA !== s_t.wdata) begin errors++; $display("FAIL rnd_hwdata cyc=%0d got=%h exp=%h", cyc, HWDATA, s_t.wdata); end
                    end
                    s_v = 1'b0;
                end else begin
                    s_wait--;
                end
            end
            // Address phase on the shared bus.
            if (HTRANS == 2'b10 && exp_tr == 2'b10) begin
                sel_obs = HADDR[31];
                if (prev_lock) exp_sel = prev_sel;
                else if (pq[0].size() != 0 && pq[1].size() != 0) exp_sel = ARB_RR ? ~last : 1'b0;
                else exp_sel = (pq[0].size() == 0);
                checks++; if (sel_obs !== exp_sel) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, sel_obs, exp_sel); end
                if (pq[sel_obs].size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_unknown cyc=%0d got=%h exp=queued transfer", cyc, HADDR);
                end else begin
                    t = pq[sel_obs][0];
                    checks++; if ({HADDR, HWRITE, HSIZE} !== {t.addr, t.wr, t.size}) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, {HADDR, HWRITE, HSIZE}, {t.addr, t.wr, t.size}); end
                    if (HREADY) begin
                        s_t = pq[sel_obs].pop_front();
                        s_v = 1'b1;
                        s_wait = $urandom_range(0, max_wait);
                        last = sel_obs;
                        grants.push_back(int'(sel_obs));
                        accepts++;
                    end
                end
                prev_lock = !HREADY; prev_sel = sel_obs; prev_ctl = {HADDR, HWRITE, HSIZE};
            end else begin
                prev_lock = 1'b0;
            end
            // Master side: finish data phase, then accept any new address.
            for (int m = 0; m < 2; m++) begin
                if ((m == 0 ? HREADY_M0 : HREADY_M1) === 1'b1) begin
                    if (dp_v[m]) begin
                        if (!dp_t[m].wr) begin
                            rd_m = (m == 0) ? HRDATA_M0 : HRDATA_M1;
                            checks++; if (rd_m !== rd_fn(dp_t[m].addr)) begin errors++; $display("FAIL rnd_hrdata_m%0d cyc=%0d got=%h exp=%h", m, cyc, rd_m, rd_fn(dp_t[m].addr)); end
                        end
                        dp_v[m] = 1'b0;
                    end
                    if (addr_v[m]) begin
                        pq[m].push_back(addr_t[m]);
                        dp_t[m] = addr_t[m]; dp_v[m] = 1'b1; addr_v[m] = 1'b0;
                    end
                end
            end
            busy = (mlist[0].size() + mlist[1].size() + pq[0].size() + pq[1].size()) != 0
                   || addr_v[0] || addr_v[1] || dp_v[0] || dp_v[1] || s_v;
        end
        checks++; if (busy) begin errors++; $display("FAIL rnd_timeout got=busy after %0d cycles exp=drained", cyc); end
        checks++; if (accepts !== 2 * n) begin errors++; $display("FAIL rnd_count got=%0d exp=%0d", accepts, 2 * n); end
        @(negedge HCLK);
        idle_masters();
        HREADY = 1'b1;
    endtask

    task automatic test_back_to_back();
        run_traffic(8, 100, 0);
        checks++; if (grants.size() != 16) begin errors++; $display("FAIL b2b_len got=%0d exp=16", grants.size()); end
        for (int i = 0; i < grants.size() && i < 16; i++) begin
            checks++; if (grants[i] != (i % 2)) begin errors++; $display("FAIL b2b_grant%0d got=%0d exp=%0d", i, grants[i], i % 2); end
        end
    endtask

    task automatic test_random();
        run_traffic(40, 60, 3);
        run_traffic(30, 90, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_wait_lock();
        test_m1_write();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
